// File: rtl/i2s_wfifo_arbiter.sv
// i2s_wfifo_arbiter: two sample streams share a ping-pong write FIFO. The block claims one
// buffer at a time, grants it to a single requester, streams words into it and then releases it.
// Ports:
//   clk, rst (async, active low)  enable
//   wfifo_ready/size  -> buffer availability and capacity
//   wfifo_activate/strobe/data -> buffer ownership and write port
//   reqN_valid/data/last/ready -> requester streams
//   grant, busy, buf_count     -> status
module i2s_wfifo_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  wfifo_ready,
  input  logic [23:0] wfifo_size,
  output logic [1:0]  wfifo_activate,
  output logic        wfifo_strobe,
  output logic [31:0] wfifo_data,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] buf_count
);

  typedef enum logic [2:0] {IDLE, ACQUIRE, ARB, XFER, DRAIN, RELEASE} state_t;

  state_t      state, state_nxt;
  logic [23:0] size_q, size_nxt;
  logic [23:0] count_q, count_nxt;
  logic [15:0] idle_q, idle_nxt;
  logic        last1_q, last1_nxt;   // 1 when requester 1 held the previous buffer
  logic [1:0]  act_nxt, grant_nxt;
  logic        strobe_nxt;
  logic [31:0] data_nxt;
  logic [15:0] bufc_nxt;

  logic        room, accept, acc_last, timeout;
  logic [31:0] acc_data;

  assign room       = (count_q < size_q);
  assign req0_ready = (state == XFER) && grant[0] && enable && room;
  assign req1_ready = (state == XFER) && grant[1] && enable && room;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign acc_data   = grant[1] ? req1_data : req0_data;
  assign acc_last   = grant[1] ? req1_last : req0_last;
  // Fires on the TIMEOUT-th consecutive idle cycle; an accept in that cycle wins.
  assign timeout    = (count_q != 24'd0) && (idle_q == TIMEOUT - 16'd1);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    size_nxt   = size_q;
    count_nxt  = count_q;
    idle_nxt   = idle_q;
    last1_nxt  = last1_q;
    act_nxt    = wfifo_activate;
    grant_nxt  = grant;
    strobe_nxt = 1'b0;
    data_nxt   = wfifo_data;
    bufc_nxt   = buf_count;
    case (state)
      IDLE: begin
        if (enable && (wfifo_activate == 2'b00) && (wfifo_ready != 2'b00)) begin
          act_nxt   = wfifo_ready[0] ? 2'b01 : 2'b10;
          size_nxt  = wfifo_size;
          state_nxt = ACQUIRE;
        end
      end
      ACQUIRE: begin
        count_nxt = 24'd0;
        idle_nxt  = 16'd0;
        state_nxt = (size_q == 24'd0) ? RELEASE : ARB;
      end
      ARB: begin
        if (!enable) begin
          state_nxt = RELEASE;
        end else if (req0_valid && req1_valid) begin
          grant_nxt = last1_q ? 2'b01 : 2'b10;
          state_nxt = XFER;
        end else if (req0_valid) begin
          grant_nxt = 2'b01;
          state_nxt = XFER;
        end else if (req1_valid) begin
          grant_nxt = 2'b10;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          strobe_nxt = 1'b1;
          data_nxt   = acc_data;
          count_nxt  = count_q + 24'd1;
          idle_nxt   = 16'd0;
          if ((count_q + 24'd1 == size_q) || acc_last) state_nxt = DRAIN;
        end else if (!enable || timeout) begin
          state_nxt = DRAIN;
        end else if (count_q != 24'd0) begin
          idle_nxt = idle_q + 16'd1;
        end
      end
      DRAIN: begin
        // The strobe of the final accept is visible this cycle; ownership is held one more.
        state_nxt = RELEASE;
      end
      RELEASE: begin
        act_nxt   = 2'b00;
        grant_nxt = 2'b00;
        if (grant != 2'b00) last1_nxt = grant[1];
        bufc_nxt  = buf_count + 16'd1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      size_q         <= 24'd0;
      count_q        <= 24'd0;
      idle_q         <= 16'd0;
      last1_q        <= 1'b1;
      wfifo_activate <= 2'b00;
      grant          <= 2'b00;
      wfifo_strobe   <= 1'b0;
      wfifo_data     <= 32'd0;
      buf_count      <= 16'd0;
    end else begin
      state          <= state_nxt;
      size_q         <= size_nxt;
      count_q        <= count_nxt;
      idle_q         <= idle_nxt;
      last1_q        <= last1_nxt;
      wfifo_activate <= act_nxt;
      grant          <= grant_nxt;
      wfifo_strobe   <= strobe_nxt;
      wfifo_data     <= data_nxt;
      buf_count      <= bufc_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_wfifo_arbiter.sv
module tb_i2s_wfifo_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  wfifo_ready = 2'b00;
  logic [23:0] wfifo_size = 24'd0;
  logic [1:0]  wfifo_activate;
  logic        wfifo_strobe;
  logic [31:0] wfifo_data;
  logic        req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
  logic [31:0] req0_data = 32'd0;
  logic        req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
  logic [31:0] req1_data = 32'd0;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] buf_count;

  always #5 clk = ~clk;

  i2s_wfifo_arbiter #(.TIMEOUT(16'd16)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .wfifo_ready(wfifo_ready), .wfifo_size(wfifo_size),
    .wfifo_activate(wfifo_activate), .wfifo_strobe(wfifo_strobe), .wfifo_data(wfifo_data),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .grant(grant), .busy(busy), .buf_count(buf_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester sources: word lists with per-word idle gaps before presentation.
  logic [31:0] sdata [2][64];
  logic        slast [2][64];
  int          sgap  [2][64];
  int          snum  [2];
  int          sidx  [2];
  int          sgc   [2];
  bit          sen   [2];
  logic [1:0]  acc;
  logic [1:0]  vv;

  always @(posedge clk) begin
    acc = {req1_valid && req1_ready, req0_valid && req0_ready};
    #1;
    for (int n = 0; n < 2; n++) begin
      if (acc[n]) begin
        sidx[n]++;
        if (sidx[n] < snum[n]) sgc[n] = sgap[n][sidx[n]];
      end
      if (!sen[n] || sidx[n] >= snum[n]) vv[n] = 1'b0;
      else if (sgc[n] > 0) begin vv[n] = 1'b0; sgc[n]--; end
      else vv[n] = 1'b1;
    end
    req0_valid = vv[0];
    req0_data  = sdata[0][sidx[0] % 64];
    req0_last  = slast[0][sidx[0] % 64] && vv[0];
    req1_valid = vv[1];
    req1_data  = sdata[1][sidx[1] % 64];
    req1_last  = slast[1][sidx[1] % 64] && vv[1];
  end

  task automatic start_src(input int n, input int num);
    sidx[n] = 0;
    snum[n] = num;
    sgc[n]  = sgap[n][0];
    sen[n]  = 1'b1;
  endtask

  // Monitor: one record per buffer ownership period, plus running invariants.
  typedef struct { int bufi; logic [1:0] gnt; int nw; int gap; } rec_t;
  rec_t        recs[$];
  logic [31:0] obs_w[$];
  logic [31:0] exp_w[$];
  rec_t        cur;
  logic [1:0]  act_prev = 2'b00;
  int          cyc = 0;
  int          last_strobe_cyc = 0;
  bit          cont_mode = 1'b0;

  always @(negedge clk) begin
    cyc++;
    chk("strobe_without_activate", wfifo_strobe && (wfifo_activate == 2'b00), 1'b0);
    chk("activate_onehot", $countones(wfifo_activate) <= 1, 1'b1);
    chk("ready_ungranted", {req1_ready & ~grant[1], req0_ready & ~grant[0]}, 2'b00);
    if (wfifo_activate != 2'b00 && act_prev == 2'b00) begin
      cur.bufi = wfifo_activate[1] ? 1 : 0;
      cur.gnt  = 2'b00;
      cur.nw   = 0;
      cur.gap  = -1;
    end
    if (wfifo_activate != 2'b00 && grant != 2'b00) begin
      if (cur.gnt == 2'b00) cur.gnt = grant;
      else chk("grant_stable", grant, cur.gnt);
    end
    if (wfifo_strobe) begin
      obs_w.push_back(wfifo_data);
      cur.nw++;
      last_strobe_cyc = cyc;
      chk("count_le_size", cur.nw <= int'(wfifo_size), 1'b1);
    end
    if (wfifo_activate == 2'b00 && act_prev != 2'b00) begin
      cur.gap = (cur.nw > 0) ? cyc - last_strobe_cyc : -1;
      recs.push_back(cur);
      if (cont_mode) wfifo_ready = (cur.bufi == 0) ? 2'b10 : 2'b01;
    end
    act_prev = wfifo_activate;
  end

  task automatic wait_bufs(input logic [15:0] target, input int budget, input string tag);
    int k = 0;
    while (buf_count !== target && k < budget) begin @(negedge clk); k++; end
    chk(tag, buf_count, target);
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic clean();
    int k = 0;
    enable = 1'b0;
    sen[0] = 1'b0;
    sen[1] = 1'b0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    chk("clean_idle", busy, 1'b0);
    repeat (2) @(negedge clk);
    recs.delete(); obs_w.delete(); exp_w.delete();
  endtask

  task automatic chk_rec(input int i, input int b, input logic [1:0] g, input int nw, input int gap);
    if (i < recs.size()) begin
      chk($sformatf("rec%0d_buf", i), recs[i].bufi, b);
      chk($sformatf("rec%0d_grant", i), recs[i].gnt, g);
      chk($sformatf("rec%0d_words", i), recs[i].nw, nw);
      chk($sformatf("rec%0d_gap", i), recs[i].gap, gap);
    end else begin
      chk($sformatf("rec%0d_missing", i), recs.size(), i + 1);
    end
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_nwords"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), obs_w[i], exp_w[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;
    int k, r, sz, cnt;
    int exp_nw[$];
    int exp_gap[$];
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 64; i++) begin sdata[n][i] = 32'd0; slast[n][i] = 1'b0; sgap[n][i] = 0; end
    snum[0] = 0; snum[1] = 0; sidx[0] = 0; sidx[1] = 0; sgc[0] = 0; sgc[1] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_activate", wfifo_activate, 2'b00);
    chk("rst_strobe", wfifo_strobe, 1'b0);
    chk("rst_data", wfifo_data, 32'd0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_buf_count", buf_count, 16'd0);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    rst = 1'b1;
    @(negedge clk);

    // Single stream, size 4: 0-3, 4-7 by size, 8-9 by timeout
    for (int i = 0; i < 10; i++) sdata[0][i] = i;
    wfifo_size = 24'd4; wfifo_ready = 2'b01; start_src(0, 10); enable = 1'b1;
    wait_bufs(16'd3, 400, "single_bufs");
    chk_rec(0, 0, 2'b01, 4, 2);
    chk_rec(1, 0, 2'b01, 4, 2);
    chk_rec(2, 0, 2'b01, 2, 18);
    for (int i = 0; i < 10; i++) exp_w.push_back(i);
    chk_words("single");
    clean();

    // enable dropped while waiting in ARB
    base = buf_count; wfifo_size = 24'd4; wfifo_ready = 2'b01; enable = 1'b1;
    repeat (6) @(negedge clk);
    chk("arb_busy", busy, 1'b1);
    chk("arb_activate", wfifo_activate, 2'b01);
    chk("arb_grant", grant, 2'b00);
    enable = 1'b0;
    wait_bufs(base + 16'd1, 20, "arb_drop_bufs");
    chk_rec(0, 0, 2'b00, 0, -1);
    chk_words("arb_drop");
    clean();

    // size 0: release with no grant and no strobes
    base = buf_count; wfifo_size = 24'd0; wfifo_ready = 2'b01;
    for (int i = 0; i < 4; i++) sdata[0][i] = $urandom;
    start_src(0, 4); enable = 1'b1;
    wait_bufs(base + 16'd1, 50, "size0_bufs");
    chk_rec(0, 0, 2'b00, 0, -1);
    chk("size0_consumed", sidx[0], 0);
    chk_words("size0");
    clean();

    // last flag on the 3rd word of requester 1, buffer 1 only
    base = buf_count; wfifo_size = 24'd8; wfifo_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin sdata[1][i] = $urandom; slast[1][i] = (i == 2); end
    start_src(1, 4); enable = 1'b1;
    wait_bufs(base + 16'd1, 100, "last_bufs");
    chk_rec(0, 1, 2'b10, 3, 2);
    chk("last_consumed", sidx[1], 3);
    for (int i = 0; i < 3; i++) exp_w.push_back(sdata[1][i]);
    chk_words("last");
    for (int i = 0; i < 4; i++) slast[1][i] = 1'b0;
    clean();

    // timeout boundary: 15 idle cycles keep the buffer, 16 release it
    for (int t = 0; t < 2; t++) begin
      base = buf_count; wfifo_size = 24'd8; wfifo_ready = 2'b01;
      for (int i = 0; i < 3; i++) begin sdata[0][i] = $urandom; sgap[0][i] = 0; end
      sgap[0][2] = 15 + t;
      start_src(0, 3); enable = 1'b1;
      wait_bufs(base + 16'd1 + 16'(t), 300, $sformatf("timeout%0d_bufs", t));
      if (t == 0) begin
        chk_rec(0, 0, 2'b01, 3, 18);
      end else begin
        chk_rec(0, 0, 2'b01, 2, 18);
        chk_rec(1, 0, 2'b01, 1, 18);
      end
      for (int i = 0; i < 3; i++) exp_w.push_back(sdata[0][i]);
      chk_words($sformatf("timeout%0d", t));
      sgap[0][2] = 0;
      clean();
    end

    // randomized single-requester streams against a chunking model
    for (int it = 0; it < 3; it++) begin
      r = $urandom_range(0, 1);
      sz = $urandom_range(1, 6);
      exp_nw.delete(); exp_gap.delete();
      for (int i = 0; i < 20; i++) begin
        sdata[r][i] = $urandom;
        slast[r][i] = ($urandom_range(0, 4) == 0);
        sgap[r][i]  = $urandom_range(0, 3);
      end
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
        exp_w.push_back(sdata[r][i]);
        cnt++;
        if (cnt == sz || slast[r][i]) begin exp_nw.push_back(cnt); exp_gap.push_back(2); cnt = 0; end
      end
      if (cnt > 0) begin exp_nw.push_back(cnt); exp_gap.push_back(18); end
      base = buf_count; wfifo_size = 24'(sz); wfifo_ready = 2'b11;
      start_src(r, 20); enable = 1'b1;
      wait_bufs(base + 16'(exp_nw.size()), 3000, $sformatf("rand%0d_bufs", it));
      for (int b = 0; b < exp_nw.size(); b++)
        chk_rec(b, 0, (r == 1) ? 2'b10 : 2'b01, exp_nw[b], exp_gap[b]);
      chk_words($sformatf("rand%0d", it));
      for (int i = 0; i < 20; i++) begin slast[r][i] = 1'b0; sgap[r][i] = 0; end
      clean();
    end

    // reset asserted mid-transfer drops activate and strobe immediately
    wfifo_size = 24'd8; wfifo_ready = 2'b01;
    for (int i = 0; i < 6; i++) sdata[0][i] = $urandom;
    start_src(0, 6); enable = 1'b1;
    k = 0;
    while (!wfifo_strobe && k < 100) begin @(negedge clk); k++; end
    chk("midrst_strobe_before", wfifo_strobe, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_activate", wfifo_activate, 2'b00);
    chk("midrst_strobe", wfifo_strobe, 1'b0);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_buf_count", buf_count, 16'd0);
    @(negedge clk);
    clean();

    // contention after reset: grants alternate starting with requester 0
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 20; i++) sdata[n][i] = $urandom;
    wfifo_size = 24'd2; cont_mode = 1'b1; wfifo_ready = 2'b11;
    start_src(0, 20); start_src(1, 20); enable = 1'b1;
    wait_bufs(16'd4, 300, "contention_bufs");
    cont_mode = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk_rec(b, b % 2, (b % 2) ? 2'b10 : 2'b01, 2, 2);
      exp_w.push_back(sdata[b % 2][(b / 2) * 2]);
      exp_w.push_back(sdata[b % 2][(b / 2) * 2 + 1]);
    end
    chk_words("contention");
    clean();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
